lfsr_crypt: RTL

LFSR_CRYPT -- requirements
Module: lfsr_crypt

---
 rtl/lfsr_crypt.sv | 138 +++++++++++++
 1 files changed

// File: rtl/lfsr_crypt.sv
// LFSR stream cipher over fixed-length frames: encrypt pads/obfuscates a message into a
// parity-tagged byte frame, decrypt strips pads and recovers the message.
module lfsr_crypt #(
  parameter int unsigned LFSR_W    = 7,
  parameter int unsigned FRAME_LEN = 64,
  parameter int unsigned OFFSET    = 8'h20
) (
  input  logic                           clk,
  input  logic                           init,
  input  logic                           req,
  output logic                           ack,
  input  logic                           mode,
  input  logic [$clog2(FRAME_LEN):0]     pre_length,
  input  logic [$clog2(FRAME_LEN):0]     msg_len,
  input  logic [LFSR_W-1:0]              tap_ptrn,
  input  logic [LFSR_W-1:0]              lfsr_seed,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [LFSR_W:0]                in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [LFSR_W:0]                out_data,
  output logic [$clog2(FRAME_LEN):0]     par_err_cnt
);

  localparam int unsigned BW = LFSR_W + 1;
  localparam int unsigned CW = $clog2(FRAME_LEN) + 1;
  localparam logic [BW-1:0] Ofs = BW'(OFFSET);
  localparam logic [CW-1:0] FrameLen = CW'(FRAME_LEN);
  localparam logic [CW-1:0] LastPos = CW'(FRAME_LEN - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]        state_q;
  logic              mode_q;
  logic [CW-1:0]     pre_q, len_q, pos_q, perr_q;
  logic [LFSR_W-1:0] taps_q, lfsr_q;
  logic              out_valid_q;
  logic [BW-1:0]     out_data_q;

  logic [CW-1:0]     pre_clip, len_clip;
  logic              running, msg_pos, need_in, emits, out_free, advance, last, par_bad;
  logic [LFSR_W-1:0] lfsr_next, enc_v;
  logic [BW-1:0]     diff, dec_byte, byte_d;

  always_comb begin
    pre_clip = pre_length;
    len_clip = msg_len;
    if (pre_length >= FrameLen) begin
      pre_clip = FrameLen;
      len_clip = '0;
    end else if (msg_len > FrameLen - pre_length) begin
      len_clip = FrameLen - pre_length;
    end
  end

  always_comb begin
    running   = (state_q == StRun);
    msg_pos   = (pos_q >= pre_q) && (pos_q < pre_q + len_q);
    // Encrypt pads need no input; decrypt pads produce no output.
    need_in   = mode_q | msg_pos;
    emits     = ~mode_q | msg_pos;
    out_free  = ~out_valid_q | out_ready;
    in_ready  = running & need_in & (~emits | out_free);
    advance   = running & (~need_in | in_valid) & (~emits | out_free);
    last      = (pos_q == LastPos);
    lfsr_next = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & taps_q)};
    diff      = in_data - Ofs;
    enc_v     = diff[LFSR_W-1:0] ^ lfsr_q;
    dec_byte  = {1'b0, in_data[LFSR_W-1:0] ^ lfsr_q} + Ofs;
    par_bad   = in_data[LFSR_W] ^ (^in_data[LFSR_W-1:0]);
    if (mode_q) begin
      byte_d = dec_byte;
    end else if (msg_pos) begin
      byte_d = {^enc_v, enc_v};
    end else begin
      byte_d = {^lfsr_q, lfsr_q};
    end
  end

  always_ff @(posedge clk) begin
    if (init) begin
      state_q     <= StIdle;
      mode_q      <= 1'b0;
      pre_q       <= '0;
      len_q       <= '0;
      pos_q       <= '0;
      perr_q      <= '0;
      taps_q      <= '0;
      lfsr_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req) begin
            state_q <= StRun;
            mode_q  <= mode;
            pre_q   <= pre_clip;
            len_q   <= len_clip;
            taps_q  <= tap_ptrn;
            lfsr_q  <= (lfsr_seed == '0) ? LFSR_W'(1) : lfsr_seed;
            pos_q   <= '0;
            perr_q  <= '0;
          end
        end
        StRun: begin
          if (advance) begin
            pos_q  <= pos_q + CW'(1);
            lfsr_q <= lfsr_next;
            if (mode_q && par_bad && (perr_q != '1)) perr_q <= perr_q + CW'(1);
            if (last) state_q <= StDone;
          end
        end
        StDone: begin
          if (!req) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase

      // Output register keeps draining after the run; data holds while stalled.
      if (advance && emits) begin
        out_valid_q <= 1'b1;
        out_data_q  <= byte_d;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign ack         = (state_q == StDone);
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign par_err_cnt = perr_q;

endmodule
